frame_align_ctrl: RTL and testbench
===================================

FRAME_ALIGN_CTRL -- requirements
Module: frame_align_ctrl

Interface
REQ-001 SHALL have parameter FRAME_PATTERN, default 8'hF0, the expected deserialized ADC frame-clock word.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 4, the CLKDIV cycles to wait after a bitslip or restart before comparing (1..15).
REQ-003 SHALL have parameter LOCK_COUNT, default 16, the consecutive matches needed to declare lock (1..255).
REQ-004 SHALL have parameter MAX_SLIPS, default 8, the slips allowed per alignment attempt before error (1..15).
REQ-005 SHALL have parameter LOSS_COUNT, default 4, the consecutive mismatches in lock that drop lock (1..15).
REQ-006 SHALL have CLKDIV  in  1  the single clock, the ISERDES divided clock; all logic is on its rising edge.
REQ-007 SHALL have RST  in  1  reset, synchronous, active-high.
REQ-008 SHALL have frame_i  in  8  parallel frame word from the ISERDES Q8..Q1 outputs, new word every CLKDIV.
REQ-009 SHALL have realign_i  in  1  level/pulse request to restart alignment.
REQ-010 SHALL have bitslip_o  out  1  bitslip pulse to the ISERDES, registered.
REQ-011 SHALL have locked_o  out  1  frame alignment achieved, registered.
REQ-012 SHALL have align_err_o  out  1  alignment failed, registered.
REQ-013 SHALL have slip_count_o  out  4  slips issued in the current attempt, registered.

Function
REQ-014 SHALL implement FSM states IDLE, SETTLE, CHECK, SLIP, LOCKED, ERROR.
REQ-015 IDLE SHALL last exactly one cycle, clear the settle, match, loss and slip counters, then go to SETTLE.
REQ-016 SETTLE SHALL hold exactly SETTLE_CYCLES cycles, ignore frame_i, then go to CHECK with the match counter at 0.
REQ-017 CHECK SHALL compare frame_i to FRAME_PATTERN every cycle; a match increments the match counter; on the match that reaches LOCK_COUNT it SHALL go to LOCKED.
REQ-018 On a mismatch in CHECK: slip_count < MAX_SLIPS -> SLIP; slip_count == MAX_SLIPS -> ERROR; a partial match run is discarded.
REQ-019 SLIP SHALL last exactly one cycle, assert bitslip_o for exactly that cycle, increment slip_count_o by 1, then go to SETTLE.
REQ-020 bitslip_o SHALL never be high on two consecutive cycles; minimum spacing between pulses is SETTLE_CYCLES+2 cycles.
REQ-021 LOCKED SHALL hold locked_o=1; each mismatch increments a loss counter, each match clears it; when it reaches LOSS_COUNT, locked_o SHALL drop and the FSM SHALL go to IDLE (new attempt, slip_count cleared).
REQ-022 ERROR SHALL hold align_err_o=1 and bitslip_o=0 until realign_i; it SHALL NOT retry on its own.
REQ-023 realign_i=1 in any state SHALL force IDLE on the next edge, clearing locked_o and align_err_o; it takes priority over all FSM transitions except RST.
REQ-024 locked_o and align_err_o SHALL be mutually exclusive at all times.
REQ-025 slip_count_o SHALL saturate at MAX_SLIPS and never wrap; it holds its value in LOCKED and ERROR.
REQ-026 Output latency: the registered outputs SHALL reflect a state entry on the same edge as that entry, so locked_o rises on the edge after the LOCK_COUNT-th matching word is sampled.

Reset
REQ-027 RST=1 SHALL on the next CLKDIV edge force state IDLE, bitslip_o=0, locked_o=0, align_err_o=0, slip_count_o=0, and all internal counters 0.
REQ-028 RST asserted mid-SLIP or mid-SETTLE SHALL abort without issuing a further bitslip pulse; RST overrides realign_i.

Verification
REQ-029 The bench SHALL cover this scenario: frame_i=8'hF0 constant from reset -> zero bitslip pulses; locked_o=1 on cycle 1+4+16 after RST release; slip_count_o=0.
REQ-030 The bench SHALL cover this scenario: ISERDES model whose word rotates one bit per bitslip, starting 3 slips from 8'hF0 -> exactly 3 single-cycle pulses spaced 6 cycles apart; lock; slip_count_o=3.
REQ-031 The bench SHALL cover this scenario: frame_i=8'h00 constant -> 8 pulses, then align_err_o=1, locked_o=0, slip_count_o=8, no further pulses for 100 cycles; a realign_i pulse then restarts with slip_count_o=0.
REQ-032 The bench SHALL cover this scenario: while locked, 3 bad words, 1 good, then 3 bad -> locked_o stays 1; 4 consecutive bad words -> locked_o=0 the next cycle and realignment starts.
REQ-033 The bench SHALL cover this scenario: 10 good words, then 1 bad in CHECK -> no lock; SLIP taken; the match counter restarts from 0 after SETTLE.
REQ-034 The bench SHALL cover this scenario: RST asserted on the SLIP cycle and held 2 cycles -> all outputs 0, no extra bitslip pulse, and a clean realignment after release.

Source files
------------

// File: rtl/frame_align_ctrl.sv
// ISERDES frame-clock word aligner: bitslips until FRAME_PATTERN is seen LOCK_COUNT times in a row,
// then monitors lock and restarts alignment after LOSS_COUNT consecutive bad words.
module frame_align_ctrl #(
    parameter logic [7:0]  FRAME_PATTERN = 8'hF0,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned LOCK_COUNT    = 16,
    parameter int unsigned MAX_SLIPS     = 8,
    parameter int unsigned LOSS_COUNT    = 4
) (
    input  logic       CLKDIV,
    input  logic       RST,
    input  logic [7:0] frame_i,
    input  logic       realign_i,
    output logic       bitslip_o,
    output logic       locked_o,
    output logic       align_err_o,
    output logic [3:0] slip_count_o
);

    localparam logic [3:0] SettleLast = 4'(SETTLE_CYCLES - 1);
    localparam logic [7:0] LockLast   = 8'(LOCK_COUNT - 1);
    localparam logic [3:0] MaxSlips   = 4'(MAX_SLIPS);
    localparam logic [3:0] LossLast   = 4'(LOSS_COUNT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StCheck,
        StSlip,
        StLocked,
        StError
    } state_e;

    state_e     r_state, w_state_d;
    logic [3:0] r_settle_cnt, w_settle_cnt_d;
    logic [7:0] r_match_cnt, w_match_cnt_d;
    logic [3:0] r_loss_cnt, w_loss_cnt_d;
    logic [3:0] r_slip_cnt, w_slip_cnt_d;
    logic       r_bitslip, r_locked, r_align_err;
    logic       w_match;

    assign w_match = (frame_i == FRAME_PATTERN);

    always_comb begin
        w_state_d      = r_state;
        w_settle_cnt_d = r_settle_cnt;
        w_match_cnt_d  = r_match_cnt;
        w_loss_cnt_d   = r_loss_cnt;
        w_slip_cnt_d   = r_slip_cnt;

        unique case (r_state)
            StIdle: begin
                w_state_d = StSettle;
            end
            StSettle: begin
                if (r_settle_cnt == SettleLast) begin
                    w_state_d      = StCheck;
                    w_settle_cnt_d = 4'd0;
                    w_match_cnt_d  = 8'd0;
                end else begin
                    w_settle_cnt_d = r_settle_cnt + 4'd1;
                end
            end
            StCheck: begin
                if (w_match) begin
                    if (r_match_cnt == LockLast) begin
                        w_state_d    = StLocked;
                        w_loss_cnt_d = 4'd0;
                    end else begin
                        w_match_cnt_d = r_match_cnt + 8'd1;
                    end
                end else begin
                    w_match_cnt_d = 8'd0;
                    // Count rises together with bitslip_o on SLIP entry; saturates at MaxSlips.
                    if (r_slip_cnt < MaxSlips) begin
                        w_state_d    = StSlip;
                        w_slip_cnt_d = r_slip_cnt + 4'd1;
                    end else begin
                        w_state_d = StError;
                    end
                end
            end
            StSlip: begin
                w_state_d      = StSettle;
                w_settle_cnt_d = 4'd0;
            end
            StLocked: begin
                if (w_match) begin
                    w_loss_cnt_d = 4'd0;
                end else if (r_loss_cnt == LossLast) begin
                    w_state_d = StIdle;
                end else begin
                    w_loss_cnt_d = r_loss_cnt + 4'd1;
                end
            end
            StError: begin
                w_state_d = StError;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase

        if (realign_i) begin
            w_state_d = StIdle;
        end

        // Every new attempt starts from clean counters.
        if (w_state_d == StIdle) begin
            w_settle_cnt_d = 4'd0;
            w_match_cnt_d  = 8'd0;
            w_loss_cnt_d   = 4'd0;
            w_slip_cnt_d   = 4'd0;
        end
    end

    always_ff @(posedge CLKDIV) begin
        if (RST) begin
            r_state      <= StIdle;
            r_settle_cnt <= 4'd0;
            r_match_cnt  <= 8'd0;
            r_loss_cnt   <= 4'd0;
            r_slip_cnt   <= 4'd0;
            r_bitslip    <= 1'b0;
            r_locked     <= 1'b0;
            r_align_err  <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_settle_cnt <= w_settle_cnt_d;
            r_match_cnt  <= w_match_cnt_d;
            r_loss_cnt   <= w_loss_cnt_d;
            r_slip_cnt   <= w_slip_cnt_d;
            r_bitslip    <= (w_state_d == StSlip);
            r_locked     <= (w_state_d == StLocked);
            r_align_err  <= (w_state_d == StError);
        end
    end

    assign bitslip_o    = r_bitslip;
    assign locked_o     = r_locked;
    assign align_err_o  = r_align_err;
    assign slip_count_o = r_slip_cnt;

endmodule

// File: tb/tb_frame_align_ctrl.sv
// Directed bench for frame_align_ctrl: clean lock, bitslip-rotating ISERDES model, error, loss, reset.
module tb_frame_align_ctrl;

    logic       CLKDIV = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] frame_i = 8'h00;
    logic       realign_i = 1'b0;
    logic       bitslip_o;
    logic       locked_o;
    logic       align_err_o;
    logic [3:0] slip_count_o;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         pulses = 0;
    int         last_pulse = -1;
    logic       prev_bs = 1'b0;
    logic       model_en = 1'b0;
    logic [7:0] model_word = 8'h00;
    logic [7:0] frame_val = 8'hF0;

    frame_align_ctrl dut (
        .CLKDIV       (CLKDIV),
        .RST          (RST),
        .frame_i      (frame_i),
        .realign_i    (realign_i),
        .bitslip_o    (bitslip_o),
        .locked_o     (locked_o),
        .align_err_o  (align_err_o),
        .slip_count_o (slip_count_o)
    );

    always #5 CLKDIV = ~CLKDIV;

    // One CLKDIV cycle: drive the word, pass the edge, sample 1ns later, track bitslip pulses.
    task automatic tick();
        frame_i = model_en ? model_word : frame_val;
        @(posedge CLKDIV);
        #1;
        cyc++;
        checks++;
        if (locked_o && align_err_o) begin
            errors++;
            $display("FAIL exclusive: cyc %0d locked_o=1 align_err_o=1, required not both", cyc);
        end
        if (bitslip_o) begin
            pulses++;
            checks++;
            if (prev_bs || (last_pulse >= 0 && cyc - last_pulse < 6)) begin
                errors++;
                $display("FAIL bitslip_spacing: cyc %0d gap %0d, required >= 6", cyc,
                         cyc - last_pulse);
            end
            last_pulse = cyc;
            if (model_en) model_word = {model_word[6:0], model_word[7]};
        end
        prev_bs = bitslip_o;
    endtask

    task automatic release_reset();
        RST        = 1'b0;
        cyc        = 0;
        pulses     = 0;
        last_pulse = -1;
        prev_bs    = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        repeat (2) tick();
        release_reset();
    endtask

    task automatic check_outs(input string name, input logic bs, input logic lk, input logic er,
                              input logic [3:0] sc);
        checks++;
        if ({bitslip_o, locked_o, align_err_o, slip_count_o} !== {bs, lk, er, sc}) begin
            errors++;
            $display("FAIL %s: cyc %0d got bs=%b lk=%b er=%b sc=%0d, required bs=%b lk=%b er=%b sc=%0d",
                     name, cyc, bitslip_o, locked_o, align_err_o, slip_count_o, bs, lk, er, sc);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    task automatic test_reset();
        model_en  = 1'b0;
        frame_val = 8'hF0;
        RST       = 1'b1;
        tick();
        check_outs("reset_outputs", 1'b0, 1'b0, 1'b0, 4'd0);
        tick();
        release_reset();
    endtask

    // Constant correct word: lock on edge 21, never slip. Then loss-of-lock handling.
    task automatic test_clean_lock_and_loss();
        int t;
        while (cyc < 20) tick();
        check_outs("no_lock_before_21", 1'b0, 1'b0, 1'b0, 4'd0);
        tick();
        check_outs("lock_at_21", 1'b0, 1'b1, 1'b0, 4'd0);
        check_int("clean_pulses", pulses, 0);

        for (int i = 0; i < 8; i++) begin
            frame_val = (i == 3 || i == 7) ? 8'hF0 : 8'h00;
            tick();
            check_outs("loss_tolerated", 1'b0, 1'b1, 1'b0, 4'd0);
        end
        frame_val = 8'h00;
        repeat (3) tick();
        check_outs("loss_3_bad", 1'b0, 1'b1, 1'b0, 4'd0);
        tick();
        check_outs("loss_4_bad", 1'b0, 1'b0, 1'b0, 4'd0);
        t = cyc;
        frame_val = 8'hF0;
        while (cyc < t + 20) tick();
        check_outs("relock_pending", 1'b0, 1'b0, 1'b0, 4'd0);
        tick();
        check_outs("relock", 1'b0, 1'b1, 1'b0, 4'd0);
        check_int("relock_pulses", pulses, 0);
    endtask

    // ISERDES model 3 slips away from the pattern (8'h1E -> 3C -> 78 -> F0).
    task automatic test_slip_model();
        model_en   = 1'b1;
        model_word = 8'h1E;
        do_reset();
        while (cyc < 38) tick();
        check_outs("model_pre_lock", 1'b0, 1'b0, 1'b0, 4'd3);
        check_int("model_pulses", pulses, 3);
        check_int("model_last_pulse_cyc", last_pulse, 18);
        tick();
        check_outs("model_lock", 1'b0, 1'b1, 1'b0, 4'd3);
        model_en = 1'b0;
    endtask

    task automatic test_error();
        frame_val = 8'h00;
        do_reset();
        while (cyc < 53) tick();
        check_outs("err_pre", 1'b0, 1'b0, 1'b0, 4'd8);
        check_int("err_pulses", pulses, 8);
        tick();
        check_outs("err_enter", 1'b0, 1'b0, 1'b1, 4'd8);
        repeat (100) tick();
        check_outs("err_hold", 1'b0, 1'b0, 1'b1, 4'd8);
        check_int("err_no_retry", pulses, 8);
        realign_i = 1'b1;
        tick();
        realign_i = 1'b0;
        check_outs("realign_idle", 1'b0, 1'b0, 1'b0, 4'd0);
        repeat (6) tick();
        check_outs("realign_first_slip", 1'b1, 1'b0, 1'b0, 4'd1);
    endtask

    // 10 good words then a bad one: slip, and the match run restarts after settling.
    task automatic test_partial_match();
        frame_val = 8'hF0;
        do_reset();
        while (cyc < 37) begin
            frame_val = (cyc == 15) ? 8'h00 : 8'hF0;
            tick();
            if (cyc == 16) check_outs("partial_slip", 1'b1, 1'b0, 1'b0, 4'd1);
            if (cyc == 27 || cyc == 36) check_outs("partial_no_lock", 1'b0, 1'b0, 1'b0, 4'd1);
        end
        check_outs("partial_lock", 1'b0, 1'b1, 1'b0, 4'd1);
        check_int("partial_pulses", pulses, 1);
    endtask

    task automatic test_reset_mid_slip();
        frame_val = 8'h00;
        do_reset();
        while (cyc < 6) tick();
        check_outs("rst_slip_cycle", 1'b1, 1'b0, 1'b0, 4'd1);
        RST = 1'b1;
        tick();
        check_outs("rst_mid_slip", 1'b0, 1'b0, 1'b0, 4'd0);
        tick();
        check_outs("rst_hold", 1'b0, 1'b0, 1'b0, 4'd0);
        check_int("rst_pulses", pulses, 1);
        frame_val = 8'hF0;
        release_reset();
        while (cyc < 21) tick();
        check_outs("rst_clean_lock", 1'b0, 1'b1, 1'b0, 4'd0);
        check_int("rst_clean_pulses", pulses, 0);
    endtask

    initial begin
        test_reset();
        test_clean_lock_and_loss();
        test_slip_model();
        test_error();
        test_partial_match();
        test_reset_mid_slip();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
